// File: rtl/ff_bank_arbiter.sv
// ff_bank_arbiter
// Round-robin arbiter and write sequencer that shares one external N-bit
// flip-flop register bank among REQ requesters. The winner's data is written
// to the bank and read back one cycle later. A mismatch triggers a retry,
// up to MAX_RETRY times. The requester then gets a one-cycle gnt, with err
// set when the write never verified.
//
// Ports:
//   Clock    - system clock, rising edge
//   Resetn   - synchronous, active-low reset
//   req      - per-requester write request (level)
//   wdata    - packed write data, requester i uses [i*N +: N]
//   gnt      - one-hot, one-cycle completion acknowledge
//   err      - valid with gnt, 1 = write failed after all retries
//   ff_d     - data to the bank D inputs (holds outside WRITE)
//   ff_load  - bank load enable, one-cycle pulse per write attempt
//   ff_q     - bank Q outputs (one cycle load-to-read latency)
//   busy     - high whenever not idle
//   owner    - index of the requester being served, 0 when idle
//   lock     - (only with FFARB_LOCK_EN) per-requester bank lock
//
// Optional feature macro: FFARB_LOCK_EN. When it is defined, a requester
// holding lock and req at DONE is served again directly, without a pass
// through IDLE and without advancing the round-robin pointer.

module ff_bank_arbiter #(
    parameter int N         = 2,
    parameter int REQ       = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [REQ-1:0]   req,
    input  logic [REQ*N-1:0] wdata,
    output logic [REQ-1:0]   gnt,
    output logic             err,
    output logic [N-1:0]     ff_d,
    output logic             ff_load,
    input  logic [N-1:0]     ff_q,
    output logic             busy,
    output logic [2:0]       owner
`ifdef FFARB_LOCK_EN
    ,
    input  logic [REQ-1:0]   lock
`endif
);

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

    state_t         state_reg;
    logic [2:0]     ptr_reg;
    logic [2:0]     owner_reg;
    logic [2:0]     retry_reg;
    logic [N-1:0]   data_reg;
    logic [N-1:0]   ff_d_reg;
    logic [REQ-1:0] gnt_reg;
    logic           err_reg;
    logic           ff_load_reg;
    logic           busy_reg;

    // Requester-indexed views padded to 8 entries, so a 3-bit index is always in range.
    logic [N-1:0]   slice [8];
    logic [7:0]     req_pad;
    logic [2:0]     pick_idx;
    logic [2:0]     scan_idx;
    logic [2:0]     ptr_next;
    logic [REQ-1:0] owner_onehot;
    logic           lock_hold;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slice
            if (gi < REQ) begin : g_real
                assign slice[gi] = wdata[gi*N +: N];
            end else begin : g_none
                assign slice[gi] = '0;
            end
        end
    endgenerate

    assign req_pad      = 8'(req);
    assign ptr_next     = 3'((int'(owner_reg) + 1) % REQ);
    assign owner_onehot = REQ'(1) << owner_reg;

    // Scan from the farthest offset back to ptr itself, so the requester
    // closest to ptr (in wrap order) is the last one written and wins.
    always_comb begin
        pick_idx = '0;
        scan_idx = '0;
        for (int k = REQ - 1; k >= 0; k--) begin
            scan_idx = 3'((int'(ptr_reg) + k) % REQ);
            if (req_pad[scan_idx]) begin
                pick_idx = scan_idx;
            end
        end
    end

`ifdef FFARB_LOCK_EN
    logic [7:0] lock_pad;
    assign lock_pad  = 8'(lock);
    // A failed write always releases the bank, even if lock is held.
    assign lock_hold = lock_pad[owner_reg] && req_pad[owner_reg] && !err_reg;
`else
    assign lock_hold = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            owner_reg   <= '0;
            retry_reg   <= '0;
            data_reg    <= '0;
            ff_d_reg    <= '0;
            gnt_reg     <= '0;
            err_reg     <= 1'b0;
            ff_load_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            // Pulse outputs default low; a state sets them for one cycle.
            ff_load_reg <= 1'b0;
            gnt_reg     <= '0;
            case (state_reg)
                IDLE: begin
                    if (req != '0) begin
                        owner_reg   <= pick_idx;
                        data_reg    <= slice[pick_idx];
                        ff_d_reg    <= slice[pick_idx];
                        ff_load_reg <= 1'b1;
                        retry_reg   <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= WRITE;
                    end
                end
                WRITE: begin
                    state_reg <= VERIFY;
                end
                VERIFY: begin
                    if (ff_q == data_reg) begin
                        err_reg   <= 1'b0;
                        gnt_reg   <= owner_onehot;
                        state_reg <= DONE;
                    end else if (retry_reg < 3'(MAX_RETRY)) begin
                        retry_reg   <= retry_reg + 3'd1;
                        ff_d_reg    <= data_reg;
                        ff_load_reg <= 1'b1;
                        state_reg   <= WRITE;
                    end else begin
                        err_reg   <= 1'b1;
                        gnt_reg   <= owner_onehot;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    err_reg <= 1'b0;
                    if (lock_hold) begin
                        // Same owner keeps the bank. Fresh data is captured now.
                        data_reg    <= slice[owner_reg];
                        ff_d_reg    <= slice[owner_reg];
                        ff_load_reg <= 1'b1;
                        retry_reg   <= '0;
                        state_reg   <= WRITE;
                    end else begin
                        ptr_reg   <= ptr_next;
                        owner_reg <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign err     = err_reg;
    assign ff_d    = ff_d_reg;
    assign ff_load = ff_load_reg;
    assign busy    = busy_reg;
    assign owner   = owner_reg;

endmodule
